bpu_pht_update_queue: RTL and testbench
=======================================

Name: bpu_pht_update_queue

Overview:
- Buffers branch outcomes retired by the ROB and schedules them onto the PHT write ports of the branch predictor.
- The ROB retires up to 5 branches per cycle; the PHT accepts only WR_PORTS updates per cycle.
- The block compacts valid retire lanes in order, queues them, drains them in FIFO order, and back-pressures the ROB when space runs low.
- It sits between ROB commit and the predictor's PHT update inputs.

Parameters:
- RETIRE_W, 5: number of ROB retire lanes.
- WR_PORTS, 2: number of PHT update ports drained per cycle.
- DEPTH, 16: queue entries; power of two, and DEPTH >= RETIRE_W + WR_PORTS.
- IDX_W, 10: PHT index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_rob  in  [RETIRE_W]x1  lane carries a retired conditional branch.
- index_rob  in  [RETIRE_W]x IDX_W  PHT index captured at prediction time.
- Branch_rob  in  [RETIRE_W]x1  resolved direction; 1 = taken.
- stall_rob  out  1  ROB must not retire branches this cycle.
- pht_ready  in  1  PHT accepts updates this cycle.
- upd_valid  out  [WR_PORTS]x1  update port p is valid.
- upd_index  out  [WR_PORTS]x IDX_W  PHT index for port p.
- upd_taken  out  [WR_PORTS]x1  direction for port p.
- occupancy  out  clog2(DEPTH+1)  current entry count.

Behaviour:
- Storage:
  - Circular buffer of {index, taken}.
  - head and tail pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - count register ranges 0..DEPTH.
- Reset:
  - head = tail = count = 0 on the first rising edge with rst = 1.
  - All upd_valid = 0, stall_rob = 0, occupancy = 0.
  - Asserting rst mid-operation discards all queued entries; no partial drain.
- Enqueue:
  - Valid lanes are compacted in ascending lane order (lane 0 oldest).
  - The k-th valid lane is written at tail + k.
  - tail and count advance by popcount(valid_rob) at the clock edge.
  - Invalid lanes consume no slot, e.g. valid = 5'b10101 writes lanes 0, 2, 4 into 3 consecutive slots.
- Stall:
  - stall_rob = (DEPTH - count) < RETIRE_W, combinational from the registered count only.
  - Entries popped in the same cycle do not relieve the stall.
  - While stall_rob = 1, all valid_rob are ignored and nothing is enqueued. Asserting valid_rob while stalled is a protocol violation; the bench flags it.
- Drain (combinational view of head):
  - upd_valid[p] = (count > p).
  - upd_index[p] and upd_taken[p] come from slot head + p.
  - When pht_ready = 1, n = min(count, WR_PORTS) entries pop at the edge.
  - When pht_ready = 0, outputs hold stable and nothing pops.
- Latency:
  - An entry enqueued at edge N is visible on upd_* in cycle N+1 at the earliest.
  - There is no same-cycle bypass from index_rob to upd_*.
- Simultaneous enqueue and pop in one cycle:
  - count_next = count + n_enq - n_pop.
  - With the stall rule and DEPTH >= RETIRE_W + WR_PORTS, count never exceeds DEPTH and never goes below 0.
- Ordering:
  - Strict FIFO; port 0 always carries the oldest entry.
  - Duplicate indices are not merged; each update is applied separately, in order.
- Full/empty:
  - count = 0: all upd_valid = 0.
  - count = DEPTH: stall_rob = 1 and pops continue.
- occupancy = count, registered.

Optional Feature:
- Macro: BPU_PHT_UPD_STAT_EN.
- With the macro defined:
  - Adds output stat_enq (32 bits): total entries enqueued.
  - Adds output stat_stall (32 bits): cycles with stall_rob = 1.
  - Adds output stat_hold (32 bits): cycles with count > 0 && pht_ready = 0.
  - All counters saturate at 32'hFFFFFFFF and clear on rst.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst for 2 cycles, no valid -> upd_valid = 00, stall_rob = 0, occupancy = 0 on every cycle.
2. Sparse compaction: cycle 0 valid = 5'b10101, index = {4:0x3FF, 2:0x011, 0:0x005}, taken = {1, 0, 1}, pht_ready = 1.
   - Cycle 1: port0 = (0x005, 1), port1 = (0x011, 0).
   - Cycle 2: port0 = (0x3FF, 1), port1 invalid.
   - Cycle 3: empty.
3. Fill to stall: pht_ready = 0, full 5-lane retires on 3 consecutive cycles.
   - count = 15 after the third retire.
   - stall_rob = 1 from cycle 3 (free = 1 < 5).
   - A 4th retire with valid asserted while stalled is not enqueued; occupancy stays 15.
4. Drain with wrap: continue test 3 with pht_ready = 1.
   - Entries emerge 2 per cycle in exact enqueue order, crossing the slot 15 -> 0 wrap.
   - stall_rob deasserts on the cycle count reaches 11 (free = 5).
5. Concurrent enqueue/pop: steady state of 2 valid lanes per cycle with pht_ready = 1 -> occupancy stays constant at 2, stall_rob = 0, and output order matches input order over 100 cycles.
6. Reset mid-operation: with occupancy = 9, assert rst for 1 cycle -> next cycle occupancy = 0, upd_valid = 00, and no stale entry reappears after new enqueues.
   - With BPU_PHT_UPD_STAT_EN defined: stat_* = 0 after reset, and stat_enq matches the scoreboard count.

Source files
------------

// File: rtl/bpu_pht_update_queue.sv
// rtl/bpu_pht_update_queue.sv - compacting FIFO from ROB branch retire lanes to PHT update ports
// Optional event counters are enabled by defining BPU_PHT_UPD_STAT_EN.
module bpu_pht_update_queue #(
  parameter int RETIRE_W = 5,
  parameter int WR_PORTS = 2,
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [RETIRE_W-1:0]                  valid_rob,
  input  logic [RETIRE_W-1:0][IDX_W-1:0]       index_rob,
  input  logic [RETIRE_W-1:0]                  Branch_rob,
  output logic                                 stall_rob,
  input  logic                                 pht_ready,
  output logic [WR_PORTS-1:0]                  upd_valid,
  output logic [WR_PORTS-1:0][IDX_W-1:0]       upd_index,
  output logic [WR_PORTS-1:0]                  upd_taken,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
`ifdef BPU_PHT_UPD_STAT_EN
  ,
  output logic [31:0]                          stat_enq,
  output logic [31:0]                          stat_stall,
  output logic [31:0]                          stat_hold
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int LANE_W = $clog2(RETIRE_W+1);

  logic [IDX_W:0]     mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free_slots;
  logic [CNT_W-1:0]   n_enq;
  logic [CNT_W-1:0]   n_pop;
  logic [LANE_W-1:0]  lane_off [RETIRE_W];
  logic [LANE_W-1:0]  lane_cnt;

  // Stall looks only at the registered count; same-cycle pops never relieve it.
  assign free_slots = CNT_W'(DEPTH) - count;
  assign stall_rob  = free_slots < CNT_W'(RETIRE_W);
  assign occupancy  = count;

  // Running prefix count gives each valid lane its slot offset from tail.
  always_comb begin
    lane_cnt = '0;
    for (int l = 0; l < RETIRE_W; l++) begin
      lane_off[l] = lane_cnt;
      lane_cnt    = lane_cnt + LANE_W'(valid_rob[l]);
    end
  end

  assign n_enq = stall_rob ? '0 : CNT_W'(lane_cnt);

  always_comb begin
    n_pop = '0;
    if (pht_ready) begin
      if (count > CNT_W'(WR_PORTS)) n_pop = CNT_W'(WR_PORTS);
      else                          n_pop = count;
    end
  end

  always_comb begin
    for (int p = 0; p < WR_PORTS; p++) begin
      upd_valid[p]                 = count > CNT_W'(p);
      {upd_index[p], upd_taken[p]} = mem[head + PTR_W'(p)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + n_enq - n_pop;
    end
  end

  // Storage needs no reset: slots are only observable below count.
  always_ff @(posedge clk) begin
    for (int l = 0; l < RETIRE_W; l++) begin
      if (!stall_rob && valid_rob[l])
        mem[tail + PTR_W'(lane_off[l])] <= {index_rob[l], Branch_rob[l]};
    end
  end

`ifdef BPU_PHT_UPD_STAT_EN
  logic [32:0] enq_sum;
  assign enq_sum = {1'b0, stat_enq} + 33'(n_enq);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_enq   <= '0;
      stat_stall <= '0;
      stat_hold  <= '0;
    end else begin
      stat_enq <= enq_sum[32] ? 32'hFFFF_FFFF : enq_sum[31:0];
      if (stall_rob && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
      if (count != '0 && !pht_ready && stat_hold != 32'hFFFF_FFFF)
        stat_hold <= stat_hold + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_pht_update_queue.sv
// tb/tb_bpu_pht_update_queue.sv - self-checking bench for bpu_pht_update_queue
// Table vectors, directed corner sequences and random traffic against a queue model.
module tb_bpu_pht_update_queue;
  localparam int RW = 5;
  localparam int WP = 2;
  localparam int DP = 16;
  localparam int IW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [RW-1:0]          valid_rob;
  logic [RW-1:0][IW-1:0]  index_rob;
  logic [RW-1:0]          branch_tk;
  logic                   stall_rob;
  logic                   pht_ready;
  logic [WP-1:0]          upd_valid;
  logic [WP-1:0][IW-1:0]  upd_index;
  logic [WP-1:0]          upd_taken;
  logic [4:0]             occupancy;
`ifdef BPU_PHT_UPD_STAT_EN
  logic [31:0]            stat_enq;
  logic [31:0]            stat_stall;
  logic [31:0]            stat_hold;
`endif

  bpu_pht_update_queue #(.RETIRE_W(RW), .WR_PORTS(WP), .DEPTH(DP), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .valid_rob(valid_rob), .index_rob(index_rob),
    .Branch_rob(branch_tk), .stall_rob(stall_rob), .pht_ready(pht_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .occupancy(occupancy)
`ifdef BPU_PHT_UPD_STAT_EN
    , .stat_enq(stat_enq), .stat_stall(stat_stall), .stat_hold(stat_hold)
`endif
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          tk;
  } ent_t;

  typedef struct {
    bit                    chk_en;
    logic                  r;
    logic [RW-1:0]         v;
    logic [RW-1:0][IW-1:0] ix;
    logic [RW-1:0]         tk;
    logic                  rdy;
    logic [4:0]            e_occ;
    logic                  e_stall;
    logic [1:0]            e_uv;
    logic [IW-1:0]         e_i0;
    logic                  e_t0;
    logic [IW-1:0]         e_i1;
    logic                  e_t1;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  bit   model_ok = 0;
  int   m_enq = 0, m_stall = 0, m_hold = 0;
  int   viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and compare outputs against the queue model at the falling edge.
  task automatic sample(input logic r, input logic [RW-1:0] v, input logic [RW-1:0][IW-1:0] ix,
                        input logic [RW-1:0] tk, input logic rdy);
    rst = r; valid_rob = v; index_rob = ix; branch_tk = tk; pht_ready = rdy;
    @(negedge clk);
    if (model_ok) begin
      chk("model_occupancy", 32'(occupancy), 32'(mq.size()));
      chk("model_stall", 32'(stall_rob), 32'((DP - mq.size()) < RW));
      for (int p = 0; p < WP; p++) begin
        chk("model_upd_valid", 32'(upd_valid[p]), 32'(mq.size() > p));
        if (p < mq.size()) begin
          chk("model_upd_index", 32'(upd_index[p]), 32'(mq[p].idx));
          chk("model_upd_taken", 32'(upd_taken[p]), 32'(mq[p].tk));
        end
      end
`ifdef BPU_PHT_UPD_STAT_EN
      chk("model_stat_enq", stat_enq, 32'(m_enq));
      chk("model_stat_stall", stat_stall, 32'(m_stall));
      chk("model_stat_hold", stat_hold, 32'(m_hold));
`endif
    end
  endtask

  // Apply the queue rules to the model, then move past the clock edge.
  task automatic advance();
    bit stl;
    int npop;
    stl = (DP - mq.size()) < RW;
    if (rst) begin
      mq.delete();
      m_enq = 0; m_stall = 0; m_hold = 0;
      model_ok = 1;
    end else begin
      if (stl) m_stall++;
      if (mq.size() > 0 && !pht_ready) m_hold++;
      npop = pht_ready ? ((mq.size() < WP) ? mq.size() : WP) : 0;
      repeat (npop) void'(mq.pop_front());
      if (stl) begin
        if (valid_rob != '0) viol++;
      end else begin
        for (int l = 0; l < RW; l++)
          if (valid_rob[l]) begin
            mq.push_back('{idx: index_rob[l], tk: branch_tk[l]});
            m_enq++;
          end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit c, logic r, logic [RW-1:0] v, logic [RW*IW-1:0] ix,
                              logic [RW-1:0] tk, logic rdy, logic [4:0] eo, logic es,
                              logic [1:0] eu, logic [IW-1:0] i0, logic t0,
                              logic [IW-1:0] i1, logic t1);
    vec_t x;
    x.chk_en = c; x.r = r; x.v = v; x.ix = ix; x.tk = tk; x.rdy = rdy;
    x.e_occ = eo; x.e_stall = es; x.e_uv = eu;
    x.e_i0 = i0; x.e_t0 = t0; x.e_i1 = i1; x.e_t1 = t1;
    return x;
  endfunction

  vec_t vt[8];

  initial begin
    logic [RW-1:0][IW-1:0] ix;
    logic [RW-1:0]         tk;
    logic [RW-1:0]         v;
    logic                  r;
    logic                  rdy;
    int                    a, b;

    rst = 1'b1; valid_rob = '0; index_rob = '0; branch_tk = '0; pht_ready = 1'b0;

    // Reset/idle, then sparse-lane compaction with known drain order.
    vt[0] = mk(0, 1, 5'b00000, '0, 5'b00000, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vt[1] = mk(1, 1, 5'b00000, '0, 5'b00000, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vt[2] = mk(1, 0, 5'b00000, '0, 5'b00000, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    vt[3] = mk(1, 0, 5'b00000, '0, 5'b00000, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    vt[4] = mk(1, 0, 5'b10101, {10'h3FF, 10'h000, 10'h011, 10'h000, 10'h005},
               5'b10001, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    vt[5] = mk(1, 0, 5'b00000, '0, 5'b00000, 1, 3, 0, 2'b11, 10'h005, 1, 10'h011, 0);
    vt[6] = mk(1, 0, 5'b00000, '0, 5'b00000, 1, 1, 0, 2'b01, 10'h3FF, 1, 0, 0);
    vt[7] = mk(1, 0, 5'b00000, '0, 5'b00000, 1, 0, 0, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      sample(vt[i].r, vt[i].v, vt[i].ix, vt[i].tk, vt[i].rdy);
      if (vt[i].chk_en) begin
        chk("tbl_occupancy", 32'(occupancy), 32'(vt[i].e_occ));
        chk("tbl_stall", 32'(stall_rob), 32'(vt[i].e_stall));
        chk("tbl_upd_valid", 32'(upd_valid), 32'(vt[i].e_uv));
        if (vt[i].e_uv[0]) begin
          chk("tbl_port0_index", 32'(upd_index[0]), 32'(vt[i].e_i0));
          chk("tbl_port0_taken", 32'(upd_taken[0]), 32'(vt[i].e_t0));
        end
        if (vt[i].e_uv[1]) begin
          chk("tbl_port1_index", 32'(upd_index[1]), 32'(vt[i].e_i1));
          chk("tbl_port1_taken", 32'(upd_taken[1]), 32'(vt[i].e_t1));
        end
      end
      advance();
    end

    // Fill to stall with the PHT blocked; storage starts at slot 3 so it wraps.
    for (int j = 0; j < 3; j++) begin
      for (int l = 0; l < RW; l++) ix[l] = IW'(10'h100 + 5 * j + l);
      tk = RW'($urandom);
      sample(0, 5'b11111, ix, tk, 0);
      if (j == 2) chk("stall_at_10", 32'(stall_rob), 32'd0);
      advance();
    end
    for (int l = 0; l < RW; l++) ix[l] = IW'(10'h2A0 + l);
    sample(0, 5'b11111, ix, 5'b11111, 0);
    chk("full_occupancy", 32'(occupancy), 32'd15);
    chk("full_stall", 32'(stall_rob), 32'd1);
    advance();

    // Drain two per cycle; stall releases once count reaches 11.
    for (int d = 0; d < 8; d++) begin
      sample(0, '0, '0, '0, 1);
      chk("drain_occupancy", 32'(occupancy), 32'(15 - 2 * d));
      chk("drain_port0_index", 32'(upd_index[0]), 32'(10'h100 + 2 * d));
      chk("drain_stall", 32'(stall_rob), 32'((15 - 2 * d) > 11));
      advance();
    end
    sample(0, '0, '0, '0, 1);
    chk("drained_empty", 32'(upd_valid), 32'd0);
    advance();

    // Steady state: two random lanes in, two out, every cycle.
    for (int c = 0; c <= 100; c++) begin
      a = $urandom_range(0, RW - 2);
      b = $urandom_range(a + 1, RW - 1);
      v = '0; v[a] = 1'b1; v[b] = 1'b1;
      for (int l = 0; l < RW; l++) ix[l] = IW'($urandom);
      tk = RW'($urandom);
      sample(0, v, ix, tk, 1);
      if (c > 0) begin
        chk("steady_occupancy", 32'(occupancy), 32'd2);
        chk("steady_stall", 32'(stall_rob), 32'd0);
      end
      advance();
    end
    repeat (2) begin
      sample(0, '0, '0, '0, 1);
      advance();
    end

    // Reset with nine entries queued; no stale entry may reappear.
    for (int l = 0; l < RW; l++) ix[l] = IW'(10'h1C0 + l);
    sample(0, 5'b11111, ix, 5'b10101, 0);
    advance();
    sample(0, 5'b01111, ix, 5'b01010, 0);
    advance();
    sample(1, 5'b00000, '0, '0, 0);
    chk("pre_reset_occupancy", 32'(occupancy), 32'd9);
    advance();
    ix = '0; ix[0] = 10'h0AA; ix[1] = 10'h0BB;
    sample(0, 5'b00011, ix, 5'b00010, 1);
    chk("post_reset_occupancy", 32'(occupancy), 32'd0);
    chk("post_reset_upd_valid", 32'(upd_valid), 32'd0);
`ifdef BPU_PHT_UPD_STAT_EN
    chk("post_reset_stat_enq", stat_enq, 32'd0);
    chk("post_reset_stat_stall", stat_stall, 32'd0);
    chk("post_reset_stat_hold", stat_hold, 32'd0);
`endif
    advance();
    sample(0, '0, '0, '0, 1);
    chk("fresh_port0_index", 32'(upd_index[0]), 32'h0AA);
    chk("fresh_port1_index", 32'(upd_index[1]), 32'h0BB);
    chk("fresh_port1_taken", 32'(upd_taken[1]), 32'd1);
    advance();

    // Random traffic, occasional reset; the ROB honours stall.
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 99) < 45);
      v   = ((DP - mq.size()) < RW) ? '0 : RW'($urandom);
      for (int l = 0; l < RW; l++) ix[l] = IW'($urandom);
      tk = RW'($urandom);
      sample(r, v, ix, tk, rdy);
      advance();
    end

    if (viol != 0) $display("[TB] note: %0d retire attempts while stalled were ignored", viol);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
